// File: rtl/npc_lsu_pkg.sv
// Shared definitions for the npc load/store unit: funct3 encodings, FSM states
// and the access-legality helpers.
package npc_lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    // Halves need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_H, OP_HU: mis = addr_lo[0];
            OP_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Unused funct3 codes, and unsigned variants used as stores, are illegal.
    function automatic logic lsu_illegal_op(input logic [2:0] op, input logic wen);
        logic ill;
        ill = 1'b0;
        case (op)
            OP_B, OP_H, OP_W: ill = 1'b0;
            OP_BU, OP_HU:     ill = wen;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Combinational lane steering: store data replication and byte strobes on the
// way out, lane extraction and sign/zero extension on the way back.
module npc_lsu_align
    import npc_lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: replicate the datum across every lane it could occupy.
    always_comb begin
        st_wdata = 32'h0;
        st_wstrb = 4'b0000;
        case (op)
            OP_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << addr_lo;
            end
            OP_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            OP_W: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wdata = 32'h0;
                st_wstrb = 4'b0000;
            end
        endcase
    end

    // Load path: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        ld_byte = 8'h0;
        case (addr_lo)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = 8'h0;
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        ld_data = 32'h0;
        case (op)
            OP_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            OP_W:    ld_data = ld_word;
            OP_BU:   ld_data = {24'h0, ld_byte};
            OP_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// Load/store unit for the npc core: one access at a time onto a word-addressed
// data bus, with a REQ+WAIT timeout and a single-cycle response pulse.
module npc_lsu #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);
    import npc_lsu_pkg::*;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    lsu_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic [31:0]       ld_data;
    logic              timed_out;
    logic              in_req;

    npc_lsu_align u_align (
        .op       (op_q),
        .addr_lo  (addr_q[1:0]),
        .st_data  (wdata_q),
        .ld_word  (mem_resp_rdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_data  (ld_data)
    );

    // >= rather than == so a REQ exit on the limit cycle cannot skip past it.
    assign timed_out = (cnt_q >= TimeoutCnt);

    // State and captured-request registers; reset drops any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept, bus handshake, response capture and timeout.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        // Saturate so a maximal TIMEOUT cannot wrap back to zero.
        if ((state_q == StReq || state_q == StWait) && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    if (lsu_illegal_op(req_op, req_wen) || lsu_misaligned(req_op, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    state_d = StWait;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StDone;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? 32'h0 : ld_data;
                    state_d = StDone;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are gated by state so idle buses and responses read as zero.
    always_comb begin
        in_req        = (state_q == StReq);
        req_ready     = (state_q == StIdle);
        mem_req_valid = in_req;
        mem_req_we    = in_req & wen_q;
        mem_req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_req_wdata = (in_req && wen_q) ? st_wdata : 32'h0;
        mem_req_wstrb = (in_req && wen_q) ? st_wstrb : 4'b0000;
        resp_valid    = (state_q == StDone);
        resp_rdata    = (state_q == StDone) ? rdata_q : 32'h0;
        resp_err      = (state_q == StDone) & err_q;
    end

endmodule

// File: tb/tb_npc_lsu.sv
// Self-checking bench for npc_lsu: a driver issues accesses and plays the bus,
// pushing expected responses onto a queue that a monitor pops on resp_valid.
module tb_npc_lsu;
    import npc_lsu_pkg::*;

    localparam int unsigned TO = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = 32'h0;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    resp_cyc = 0;
    int    resp_cnt = 0;
    resp_t exp_q[$];

    npc_lsu #(
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model of the access semantics.
    function automatic bit model_legal(input logic wen, input logic [2:0] op, input logic [31:0] a);
        case (op)
            3'b000:  return 1'b1;
            3'b001:  return !a[0];
            3'b010:  return a[1:0] == 2'b00;
            3'b100:  return !wen;
            3'b101:  return !wen && !a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a[1:0]));
        h = 16'(w >> (16 * a[1]));
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001:  return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] op, input logic [31:0] a);
        case (op)
            3'b000:  return 4'(1 << a[1:0]);
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Monitor: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cyc <= cyc;
            resp_cnt <= resp_cnt + 1;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                check_eq("resp_rdata", resp_rdata, exp_q[0].rdata);
                check_eq("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end
        end
    end

    // One access: respond=0 withholds mem_resp_valid to force a timeout,
    // rdly holds mem_req_ready low for that many REQ cycles.
    task automatic access(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word,
                          input bit respond, input int rdly);
        bit          legal;
        resp_t       e;
        int          acc;
        int          n0;
        int          lat;
        logic [31:0] exp_addr;
        legal    = model_legal(wen, op, addr);
        exp_addr = addr & 32'hFFFF_FFFC;
        e.err    = !legal || !respond;
        e.rdata  = (legal && respond && !wen) ? model_load(op, addr, word) : 32'h0;
        exp_q.push_back(e);
        n0 = resp_cnt;

        @(negedge clk);
        check_eq("req_ready", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;

        @(negedge clk);
        if (!legal) begin
            check_eq("no_bus", 32'(mem_req_valid), 32'h0);
        end else begin
            check_eq("mreq_valid", 32'(mem_req_valid), 32'h1);
            check_eq("mreq_addr", mem_req_addr, exp_addr);
            check_eq("mreq_we", 32'(mem_req_we), 32'(wen));
            if (wen) begin
                check_eq("mreq_wdata", mem_req_wdata, model_wdata(op, wdata));
                check_eq("mreq_wstrb", 32'(mem_req_wstrb), 32'(model_wstrb(op, addr)));
            end else begin
                check_eq("mreq_wstrb_rd", 32'(mem_req_wstrb), 32'h0);
            end
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                check_eq("mreq_hold_valid", 32'(mem_req_valid), 32'h1);
                check_eq("mreq_hold_addr", mem_req_addr, exp_addr);
            end
            mem_req_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            if (respond) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = word;
                @(posedge clk);
                #1;
                mem_resp_valid = 1'b0;
                mem_resp_rdata = 32'h0;
            end
        end

        for (int i = 0; i < int'(TO) + 20 && resp_cnt == n0; i++) @(posedge clk);
        check_eq("resp_count", 32'(resp_cnt - n0), 32'h1);
        if (resp_cnt != n0) begin
            lat = resp_cyc - acc + 1;
            if (!legal) begin
                check_eq("latency_err", 32'(lat), 32'h1);
            end else if (respond) begin
                check_eq("latency", 32'(lat), 32'(3 + rdly));
            end else begin
                check_eq("timeout_window", 32'(lat >= int'(TO) + 1 && lat <= int'(TO) + 3), 32'h1);
            end
        end
    endtask

    initial begin
        int n;

        // Reset state
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_mreq_valid", 32'(mem_req_valid), 32'h0);
        check_eq("rst_mreq_wstrb", 32'(mem_req_wstrb), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Loads with lane selection and extension
        access(1'b0, OP_W,  32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
        access(1'b0, OP_B,  32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1'b1, 0);
        access(1'b0, OP_BU, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1'b1, 0);
        access(1'b0, OP_HU, 32'h8000_0002, 32'h0, 32'h80AA_BBCC, 1'b1, 0);
        access(1'b0, OP_H,  32'h8000_0002, 32'h0, 32'h80AA_BBCC, 1'b1, 0);
        access(1'b0, OP_B,  32'h8000_0001, 32'h0, 32'h1234_7F00, 1'b1, 0);
        access(1'b0, OP_H,  32'h8000_0000, 32'h0, 32'h0000_8001, 1'b1, 0);

        // Stores, including one with a stalled bus
        access(1'b1, OP_B, 32'h8000_0001, 32'h1234_5678, 32'h1122_3344, 1'b1, 0);
        access(1'b1, OP_H, 32'h8000_0002, 32'h1234_5678, 32'h1122_3344, 1'b1, 2);
        access(1'b1, OP_W, 32'h8000_0004, 32'hCAFE_BABE, 32'h1122_3344, 1'b1, 0);
        access(1'b1, OP_B, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1'b1, 0);

        // Error path: misaligned and illegal ops never touch the bus
        access(1'b0, OP_W,   32'h8000_0002, 32'h0, 32'h0, 1'b1, 0);
        access(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);
        access(1'b0, OP_HU,  32'h8000_0001, 32'h0, 32'h0, 1'b1, 0);
        access(1'b1, OP_BU,  32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);
        access(1'b0, 3'b111, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);

        // Timeout, then a late bus response that must be ignored
        access(1'b0, OP_W, 32'h8000_0020, 32'h0, 32'h5555_AAAA, 1'b0, 0);
        n = resp_cnt;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        check_eq("late_resp_ignored", 32'(resp_cnt - n), 32'h0);
        access(1'b0, OP_W, 32'h8000_0024, 32'h0, 32'h0BAD_F00D, 1'b1, 0);

        // Asynchronous reset while waiting on the bus
        n = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_op    = OP_W;
        req_addr  = 32'h8000_0030;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req_ready", 32'(req_ready), 32'h1);
        check_eq("arst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("arst_mreq_valid", 32'(mem_req_valid), 32'h0);
        check_eq("arst_mreq_addr", mem_req_addr, 32'h0);
        check_eq("arst_resp_rdata", resp_rdata, 32'h0);
        check_eq("arst_resp_err", 32'(resp_err), 32'h0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check_eq("arst_no_resp", 32'(resp_cnt - n), 32'h0);
        access(1'b0, OP_W, 32'h8000_0040, 32'h0, 32'h1357_9BDF, 1'b1, 0);

        repeat (2) @(posedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
